// File: rtl/pll_pkg.sv
// Shared definitions for the PLL lock manager and its clock-domain-crossing helpers.
package pll_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    localparam int SYNC_DEPTH = 2;

    // Smallest width able to index 0 .. value-1 (at least 1 bit).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser, cleared to zero by the synchronous reset.
module sync_2ff
    import pll_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [SYNC_DEPTH-1:0][WIDTH-1:0] stage_r;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= '0;
        end else begin
            stage_r <= {stage_r[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = stage_r[SYNC_DEPTH-1];

endmodule

// File: rtl/pll_lock_mgr.sv
// PLL supervisor: drives the PLL reset pulse, qualifies lock with timeout/retry,
// and holds the system reset request until lock has been stable.
module pll_lock_mgr
    import pll_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int RETRY_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pll_rst,
    input  logic               pll_locked,
    output logic               rst_out,
    output logic               ready,
    output logic               lost,
    output logic [RETRY_W-1:0] retries
);

    localparam int CNT_W = clog2(max2(max2(RST_CYCLES, STABLE_CYCLES), TIMEOUT_CYCLES));
    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = '1;

    if ((RST_CYCLES < 2) || (STABLE_CYCLES < 2) || (TIMEOUT_CYCLES < 2)) begin : g_bad_param
        $error("pll_lock_mgr: cycle parameters must be at least 2");
    end

    logic               locked_s;
    pll_state_e         state_r;
    pll_state_e         state_next_s;
    logic [CNT_W-1:0]   count_r;
    logic               retry_inc_s;
    logic               pll_rst_r;
    logic               rst_out_r;
    logic               ready_r;
    logic               lost_r;
    logic [RETRY_W-1:0] retries_r;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Next-state decode; lock seen in WAIT_LOCK wins over a same-cycle timeout.
    always_comb begin
        state_next_s = state_r;
        retry_inc_s  = 1'b0;
        case (state_r)
            RESET_PLL: begin
                if (count_r == RST_LAST) state_next_s = WAIT_LOCK;
                else                     state_next_s = RESET_PLL;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next_s = STABLE;
                end else if (count_r == TIMEOUT_LAST) begin
                    state_next_s = RESET_PLL;
                    retry_inc_s  = 1'b1;
                end else begin
                    state_next_s = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (!locked_s)                   state_next_s = WAIT_LOCK;
                else if (count_r == STABLE_LAST) state_next_s = RUN;
                else                             state_next_s = STABLE;
            end
            RUN: begin
                if (!locked_s) state_next_s = RESET_PLL;
                else           state_next_s = RUN;
            end
            default: state_next_s = RESET_PLL;
        endcase
    end

    // State register; the shared counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RESET_PLL;
            count_r <= '0;
        end else begin
            state_r <= state_next_s;
            if (state_next_s != state_r) count_r <= '0;
            else                         count_r <= count_r + CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state so they line up with state_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            pll_rst_r <= 1'b1;
            rst_out_r <= 1'b1;
            ready_r   <= 1'b0;
            lost_r    <= 1'b0;
            retries_r <= '0;
        end else begin
            pll_rst_r <= (state_next_s == RESET_PLL);
            rst_out_r <= (state_next_s != RUN);
            ready_r   <= (state_next_s == RUN);
            lost_r    <= (state_r == RUN) && (state_next_s == RESET_PLL);
            if (retry_inc_s && (retries_r != RETRY_MAX)) retries_r <= retries_r + RETRY_W'(1);
            else                                         retries_r <= retries_r;
        end
    end

    assign pll_rst = pll_rst_r;
    assign rst_out = rst_out_r;
    assign ready   = ready_r;
    assign lost    = lost_r;
    assign retries = retries_r;

endmodule
